// File: rtl/async_fifo_pkg.sv
// Shared sizing defaults for the single-clock elastic FIFO.
package async_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_PTR_WIDTH  = 4;
    localparam int unsigned DEPTH              = 2 ** DEFAULT_PTR_WIDTH;

    function automatic int unsigned fifo_depth(input int unsigned ptr_width);
        return 2 ** ptr_width;
    endfunction

endpackage

// File: rtl/async_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read with enable, no array reset.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Single-clock circular-buffer FIFO keeping the legacy async_fifo name and port set.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned PTR_WIDTH  = DEFAULT_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    count
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH + 1)'(1);

    logic [PTR_WIDTH:0]    wr_ptr;
    logic [PTR_WIDTH:0]    rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                    (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);
        count     = wr_ptr - rd_ptr;
        wr_accept = wr_en && !full;
        rd_accept = rd_en && !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                rd_valid <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata (wr_data),
        .re    (rd_accept),
        .raddr (rd_ptr[PTR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    // RAM read register has no reset; rd_valid masks it so reset clears rd_data at once.
    assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: model occupancy/data, compare flags and rd_data every cycle.
module tb_async_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned PW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [PW:0]   count;

    int unsigned   vectors;
    int unsigned   miscompares;

    logic [DW-1:0] sb_q [$];
    int unsigned   model_count;
    logic [DW-1:0] model_rd;

    async_fifo #(
        .DATA_WIDTH (DW),
        .PTR_WIDTH  (PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .count   (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".count"}, 32'(count), 32'(model_count));
        check_val({tag, ".empty"}, 32'(empty), 32'(model_count == 0));
        check_val({tag, ".full"},  32'(full),  32'(model_count == DEPTH));
        check_val({tag, ".rd_data"}, 32'(rd_data), 32'(model_rd));
    endtask

    // One clock cycle: drive, let the edge happen, update the model, compare.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
        bit w_acc;
        bit r_acc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        w_acc   = we && (model_count < DEPTH);
        r_acc   = re && (model_count > 0);
        @(posedge clk);
        #1;
        if (r_acc) begin
            model_rd = sb_q.pop_front();
            model_count--;
        end
        if (w_acc) begin
            sb_q.push_back(wd);
            model_count++;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    // Assert reset between edges, check outputs before any edge, release after an edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        model_count = 0;
        model_rd    = '0;
        check_state(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_n(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b1, DW'($urandom_range(0, 255)), 1'b0, tag);
        end
    endtask

    task automatic read_n(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b1, tag);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_count = 0;
        model_rd    = '0;
        rst_n       = 1'b1;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr_data     = '0;

        @(posedge clk);
        async_reset("reset");

        write_n(10, "w10");
        read_n(10, "r10");
        step(1'b0, '0, 1'b0, "idle_after_r10");

        write_n(16, "fill");
        step(1'b1, 8'h3C, 1'b0, "wr_when_full");
        read_n(16, "drain");
        read_n(2, "rd_when_empty");

        for (int unsigned lap = 0; lap < 3; lap++) begin
            write_n(12, "wrap_w");
            read_n(12, "wrap_r");
        end

        write_n(5, "pre_sim");
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b1, DW'($urandom_range(0, 255)), 1'b1, "sim_mid");
        end
        read_n(5, "post_sim");

        step(1'b1, 8'h5A, 1'b1, "sim_empty");
        read_n(1, "sim_empty_rd");

        write_n(16, "fill2");
        step(1'b1, 8'hC3, 1'b1, "sim_full");
        read_n(15, "drain2");

        write_n(6, "pre_rst");
        async_reset("mid_reset");
        step(1'b1, 8'hA5, 1'b0, "post_rst_w");
        step(1'b0, '0, 1'b1, "post_rst_r");
        check_val("a5_readback", 32'(rd_data), 32'h0000_00A5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Circular-buffer FIFO that decouples a producer and a consumer inside one clock domain, using a wr_en/full and rd_en/empty handshake.
- The established block name async_fifo and its write/read port set are kept; this revision runs all logic from a single clock.
- Used as an elastic buffer between pipeline stages.
- Depth is 2**PTR_WIDTH entries of DATA_WIDTH bits.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- PTR_WIDTH, 4, address width; depth = 2**PTR_WIDTH (16 by default).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  word to store.
- full  output  1  high when FIFO holds 2**PTR_WIDTH words.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read word.
- empty  output  1  high when FIFO holds 0 words.
- count  output  PTR_WIDTH+1  current occupancy, 0..2**PTR_WIDTH.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset (rst_n low, asynchronous, any time):
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0, empty=1, full=0.
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data immediately.
  - Release is synchronous to clk; first accepted operation is on the first rising edge after rst_n goes high.
- Pointers:
  - wr_ptr and rd_ptr are PTR_WIDTH+1-bit binary counters; the low PTR_WIDTH bits address memory and the MSB is the wrap bit.
  - Both wrap naturally from 2**(PTR_WIDTH+1)-1 to 0.
- Flags, derived from the registered pointers (glitch-free, no input-to-output combinational path):
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[MSB] != rd_ptr[MSB]) and (low bits equal).
  - count = wr_ptr - rd_ptr, modulo 2**(PTR_WIDTH+1).
- Write acceptance:
  - A write is accepted when wr_en=1 and full=0 at the rising edge: mem[wr_ptr low bits] <= wr_data, and wr_ptr increments.
  - wr_en while full is ignored: no memory change, no pointer change, no error flag.
- Read acceptance:
  - A read is accepted when rd_en=1 and empty=0 at the rising edge: rd_data <= mem[rd_ptr low bits], and rd_ptr increments.
  - Read latency is 1 cycle; the word is visible on rd_data immediately after the accepting edge.
  - rd_data holds its last value when no read is accepted.
  - rd_en while empty is ignored; rd_data is unchanged.
- Simultaneous wr_en and rd_en, evaluated against pre-edge flags:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: only the write is accepted. There is no fall-through, and the new word is readable from the next cycle.
  - Full: only the read is accepted. The freed slot is writable from the next cycle.
- Flag timing: flags and count update on the same edge as the pointer change (1-cycle visibility to the producer and consumer).
- Ordering: strict FIFO order is preserved across pointer wrap-around.

Decomposition:
- Package async_fifo_pkg: default DATA_WIDTH/PTR_WIDTH localparams and a DEPTH = 2**PTR_WIDTH helper constant.
- Sub-module fifo_mem:
  - Simple dual-port RAM of DEPTH x DATA_WIDTH.
  - Synchronous write port; synchronous registered read port with read enable.
  - No reset on the array, so it maps to block or distributed RAM.
- Top level holds the pointers, flag/count logic and the rd_data reset handling.

Test Plan:
- Reset check: assert rst_n=0 asynchronously between clock edges -> empty=1, full=0, count=0, rd_data=0 without waiting for an edge.
- Write 10 random words, then read 10: count reaches 10, empty=0 and full=0 during the writes. Each rd_data equals the written word in order, 1 cycle after the accepting edge. Empty=1 after the 10th read.
- Fill to 16: full=1 and count=16. A 17th wr_en is ignored and count stays 16. Read 16 -> data in order, then empty=1. Further rd_en leaves rd_data unchanged.
- Wrap-around: run 3 cycles of writing 12 words and reading 12 (pointers cross index 15->0 and the wrap bit toggles) -> no data loss, order preserved, correct flags throughout.
- Simultaneous wr_en and rd_en:
  - At count=5: count stays 5 and data is in order.
  - When empty: only the write is accepted (count becomes 1, rd_data unchanged).
  - When full: only the read is accepted (count becomes 15).
- Mid-operation reset: write 6 words, assert rst_n low for 1 cycle -> empty=1 and count=0. Subsequent write/read of 0xA5 returns 0xA5.
